// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide/remainder, with valid/ready handshakes.
module alu_mc #(
  parameter int WIDTH     = 32,
  parameter int LUI_SHIFT = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic             op_unsigned,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             minus,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] LUI_MASK = ~((WIDTH'(1) << LUI_SHIFT) - WIDTH'(1));
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // the producer holds its data stable while valid && !ready.
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;
  state_t state, state_next;

  logic [SW-1:0]    cnt;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] acc, mcand, mplier, quo, dvsr;
  logic [WIDTH:0]   rem, rem_sh, trial;
  logic             neg_q, neg_r;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] incr, sc_res, fin_res, res_next, mag_a, mag_b;
  logic [SW-1:0]    shamt;
  logic             sc_carry, sc_ovf, special, iterative, accept, start, load_single;

  assign shamt = b_data[SW-1:0];
  assign sum   = {1'b0, a_data} + {1'b0, b_data};
  assign diff  = {1'b0, a_data} - {1'b0, b_data};
  assign incr  = a_data + WIDTH'(1);

  // Divide-by-zero and signed MIN/-1 have fixed answers and skip the iteration.
  assign special   = (alu_op == 4'hE || alu_op == 4'hF) &&
                     (b_data == '0 || (!op_unsigned && a_data == MIN_NEG && b_data == '1));
  assign iterative = (alu_op == 4'hD) || ((alu_op == 4'hE || alu_op == 4'hF) && !special);

  assign in_ready    = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign start       = accept && iterative;
  assign load_single = accept && !iterative;
  assign busy        = (state == S_MUL) || (state == S_DIV);

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (alu_op)
      4'h0: sc_res = a_data & b_data;
      4'h1: sc_res = a_data | b_data;
      4'h2: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (a_data[WIDTH-1] == b_data[WIDTH-1]) && (sum[WIDTH-1] != a_data[WIDTH-1]);
      end
      4'h3: begin
        sc_res = incr;
        sc_ovf = !a_data[WIDTH-1] && incr[WIDTH-1];
      end
      4'h4: sc_res = b_data & LUI_MASK;
      4'h5: sc_res = a_data ^ b_data;
      4'h6: begin
        sc_res   = diff[WIDTH-1:0];
        sc_carry = diff[WIDTH];
        sc_ovf   = (a_data[WIDTH-1] != b_data[WIDTH-1]) && (diff[WIDTH-1] != a_data[WIDTH-1]);
      end
      4'h7: sc_res = WIDTH'($signed(a_data) < $signed(b_data));
      4'h8: sc_res = a_data << shamt;
      4'h9: sc_res = a_data >> shamt;
      4'hA: sc_res = $unsigned($signed(a_data) >>> shamt);
      4'hB: sc_res = WIDTH'(a_data < b_data);
      4'hC: sc_res = ~(a_data | b_data);
      4'hE: sc_res = (b_data == '0) ? '1 : a_data;
      4'hF: sc_res = (b_data == '0) ? a_data : '0;
      default: sc_res = '0;
    endcase
  end

  assign mag_a  = (!op_unsigned && a_data[WIDTH-1]) ? -a_data : a_data;
  assign mag_b  = (!op_unsigned && b_data[WIDTH-1]) ? -b_data : b_data;
  assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvsr};

  always_comb begin
    fin_res = acc;
    case (op_reg)
      4'hE:    fin_res = neg_q ? -quo : quo;
      4'hF:    fin_res = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
      default: fin_res = acc;
    endcase
  end

  assign res_next = load_single ? sc_res : fin_res;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (start) state_next = (alu_op == 4'hD) ? S_MUL : S_DIV;
      S_MUL, S_DIV: if (cnt == SW'(WIDTH-1)) state_next = S_FIN;
      S_FIN:        state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_reg <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      quo    <= '0;
      dvsr   <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cnt    <= '0;
          op_reg <= alu_op;
          acc    <= '0;
          mcand  <= a_data;
          mplier <= b_data;
          quo    <= mag_a;
          dvsr   <= mag_b;
          rem    <= '0;
          neg_q  <= !op_unsigned && (a_data[WIDTH-1] ^ b_data[WIDTH-1]);
          neg_r  <= !op_unsigned && a_data[WIDTH-1];
        end
        S_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SW'(1);
        end
        S_DIV: begin
          if (!trial[WIDTH]) begin
            rem <= trial;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + SW'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Result registers change only when a fresh result loads, so a stalled output holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      zero      <= 1'b0;
      minus     <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (load_single || state == S_FIN) begin
        out       <= res_next;
        zero      <= (res_next == '0);
        minus     <= res_next[WIDTH-1];
        carry     <= load_single && sc_carry;
        overflow  <= load_single && sc_ovf;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, parametrised-width successor to the single-cycle execute ALU.
- Adds XOR, shifts, unsigned compare, and iterative multiply/divide/remainder.
- Adds carry and overflow flags, and a valid/ready handshake on input and output.
- Sits in the execute stage; the control unit issues one operation per accepted handshake and the writeback logic consumes registered results.

Parameters:
- WIDTH, 32, datapath width; power of two, at least 8.
- LUI_SHIFT, 12, number of low bits cleared by the LUI operation.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation this cycle
- alu_op  in  4  operation code
- op_unsigned  in  1  unsigned mode for DIV/REM; ignored by all other ops
- a_data  in  WIDTH  operand A
- b_data  in  WIDTH  operand B
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer accepts the result
- out  out  WIDTH  result
- zero  out  1  out equals 0
- minus  out  1  out[WIDTH-1]
- carry  out  1  ADD carry-out or SUB borrow; 0 for other ops
- overflow  out  1  signed overflow for ADD/SUB/INC; 0 for other ops
- busy  out  1  iterative MUL/DIV/REM in progress

Behaviour:
- Clocking and reset:
  - Single clock clk; rst is synchronous and active-high.
  - Reset values: out=0, all flags=0, out_valid=0, busy=0, state IDLE, iteration counter 0.
  - Reset asserted mid-operation aborts the operation; no result is produced.
- Opcodes:
  - 0000 AND: a&b.
  - 0001 OR: a|b.
  - 0010 ADD: a+b.
  - 0011 INC: a+1.
  - 0100 LUI: b with low LUI_SHIFT bits cleared.
  - 0101 XOR: a^b.
  - 0110 SUB: a-b.
  - 0111 SLT: signed a<b, result 1 or 0.
  - 1000 SLL: a << b[log2(WIDTH)-1:0].
  - 1001 SRL: logical right shift, same shift amount.
  - 1010 SRA: arithmetic right shift, same shift amount.
  - 1011 SLTU: unsigned a<b.
  - 1100 NOR: ~(a|b).
  - 1101 MUL: low WIDTH bits of a*b.
  - 1110 DIV: quotient.
  - 1111 REM: remainder.
- Input handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted on a rising edge where in_valid && in_ready.
  - Operands and op are captured at acceptance; later input changes have no effect.
- Single-cycle ops (all except MUL/DIV/REM) and special-case divides:
  - Accepted at edge N; out_valid=1 after edge N; sustains one op per cycle when out_ready=1.
- Iterative ops:
  - MUL is shift-add, one bit per cycle.
  - DIV/REM is restoring, one quotient bit per cycle; signed mode operates on magnitudes and applies signs at the end.
  - Accepted at edge N; busy=1 for WIDTH cycles; out_valid rises after edge N+WIDTH+1.
- State machine:
  - IDLE -> MUL or DIV on acceptance of an iterative op.
  - MUL/DIV -> FIN when the counter reaches WIDTH-1.
  - FIN (sign fix-up, load output registers) -> IDLE.
  - in_ready=0 in MUL, DIV and FIN.
- Divide special cases, resolved as single-cycle:
  - b=0: DIV gives all ones; REM gives a.
  - Signed, a = most-negative value, b = -1: DIV gives a; REM gives 0.
- Output handshake:
  - out and flags are registered and update only when a new result is loaded.
  - They are held stable while out_valid && !out_ready.
  - out_valid clears on an edge with out_ready=1 unless a new result loads on the same edge.
  - A simultaneous drain and new single-cycle accept leaves out_valid=1 holding the new result.
- Flag rules:
  - zero and minus derive from the loaded result.
  - carry: ADD = carry-out of bit WIDTH-1; SUB = 1 when a<b unsigned.
  - overflow: operand signs equal and result sign differs (ADD, INC); operand signs differ and result sign differs from a (SUB).
- Arithmetic wraps modulo 2^WIDTH.

Test Plan:
- ADD 0x7FFFFFFF+1 -> out=0x80000000, overflow=1, minus=1, carry=0, one-cycle latency.
- SUB 3-5 -> out=0xFFFFFFFE, carry=1, minus=1. SUB 5-5 -> out=0, zero=1.
- MUL 0x0001_0003*0x0000_0007 -> out=0x0007_0015, out_valid exactly 33 cycles after acceptance; busy high 32 cycles; in_ready=0 throughout.
- DIV signed -7/2 -> out=0xFFFFFFFD; REM signed -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- DIV 5/0 -> 0xFFFFFFFF in one cycle; REM 5/0 -> 5; signed DIV 0x80000000/-1 -> 0x80000000, REM 0.
- Back-to-back ADDs with out_ready toggling: out held stable while stalled, no result lost or duplicated. rst asserted mid-DIV -> out_valid=0, busy=0, in_ready=1 on the next cycle.
